// File: rtl/hist_stream_feeder.sv
// Histogram-builder write-side feeder: buffers per-pixel TDC pairs during an acquisition,
// then bursts them pixel-major on data/wrEn. Optional FEEDER_DROP_CNT_EN adds a drop counter.
module hist_stream_feeder #(
   parameter int NP        = 10,
   parameter int PIXEL_NUM = 3,
   parameter int ACQ_NUM   = 2,
   parameter int DATA_NUM  = 1,
   parameter int PIX_W     = 2
) (
   input  logic             clk,
   input  logic             res,
   input  logic             acq_end,
   input  logic             tdc_valid,
   output logic             tdc_ready,
   input  logic [PIX_W-1:0] tdc_pixel,
   input  logic [NP-1:0]    tdc_word0,
   input  logic [NP-1:0]    tdc_word1,
   output logic             wrEn,
   output logic [NP-1:0]    data,
   output logic             acq_done,
   output logic             hist_done,
   output logic             overflow
`ifdef FEEDER_DROP_CNT_EN
   ,
   output logic [7:0]       drop_cnt
`endif
);

   localparam int TOT = PIXEL_NUM * DATA_NUM * 2;
   localparam int IW  = $clog2(TOT);
   localparam int CW  = $clog2(DATA_NUM + 1);
   localparam int AW  = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
   localparam logic [IW-1:0] LAST = IW'(TOT - 1);

   typedef enum logic {COLLECT, EMIT} state_t;

   state_t                                     r_state, w_state_nxt;
   logic [PIXEL_NUM-1:0][CW-1:0]               r_cnt, w_cnt_nxt;
   logic [PIXEL_NUM-1:0][DATA_NUM-1:0][1:0][NP-1:0] r_buf, w_buf_nxt;
   logic [TOT-1:0][NP-1:0]                     w_words;
   logic [IW-1:0]                              r_idx, w_rd_idx;
   logic [AW-1:0]                              r_acq;
   logic                                       w_acc, w_hit, w_drop, w_last, w_hist;

   assign w_acc  = tdc_valid && (r_state == COLLECT);
   assign w_last = (r_state == EMIT) && (r_idx == LAST);
   assign w_drop = w_acc && !w_hit;
   assign w_hist = (r_acq == AW'(ACQ_NUM - 1));

   // Post-write view of the buffer, so an event landing with acq_end is already visible to the first word
   always_comb begin
      w_buf_nxt = r_buf;
      w_cnt_nxt = r_cnt;
      w_hit     = 1'b0;
      for (int p = 0; p < PIXEL_NUM; p++) begin
         if (w_acc && (tdc_pixel == PIX_W'(p)) && (r_cnt[p] != CW'(DATA_NUM))) begin
            w_hit        = 1'b1;
            w_cnt_nxt[p] = r_cnt[p] + 1'b1;
            for (int s = 0; s < DATA_NUM; s++)
               if (r_cnt[p] == CW'(s)) w_buf_nxt[p][s] = {tdc_word0, tdc_word1};
         end
      end
   end

   // Slots beyond a pixel's count read as 0 (no-event code for the builder)
   always_comb begin
      w_words = '0;
      for (int p = 0; p < PIXEL_NUM; p++)
         for (int s = 0; s < DATA_NUM; s++)
            if (CW'(s) < w_cnt_nxt[p]) begin
               w_words[(p*DATA_NUM + s)*2]     = w_buf_nxt[p][s][1];
               w_words[(p*DATA_NUM + s)*2 + 1] = w_buf_nxt[p][s][0];
            end
   end

   assign w_rd_idx = (r_state == EMIT && !w_last) ? r_idx + 1'b1 : '0;

   always_ff @(posedge clk or negedge res) begin
      if (!res) r_state <= COLLECT;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         COLLECT: if (acq_end) w_state_nxt = EMIT;
         EMIT:    if (w_last)  w_state_nxt = COLLECT;
         default:              w_state_nxt = COLLECT;
      endcase
   end

   always_comb begin
      tdc_ready = (r_state == COLLECT);
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_buf     <= '0;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_acq     <= '0;
         wrEn      <= 1'b0;
         data      <= '0;
         acq_done  <= 1'b0;
         hist_done <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         r_buf     <= w_buf_nxt;
         acq_done  <= 1'b0;
         hist_done <= 1'b0;
         if (w_drop) overflow <= 1'b1;
         if (w_last) begin
            r_cnt     <= '0;
            wrEn      <= 1'b0;
            data      <= '0;
            acq_done  <= 1'b1;
            hist_done <= w_hist;
            r_acq     <= w_hist ? '0 : r_acq + 1'b1;
         end else begin
            r_cnt <= w_cnt_nxt;
            if (r_state == EMIT || acq_end) begin
               wrEn  <= 1'b1;
               data  <= w_words[w_rd_idx];
               r_idx <= w_rd_idx;
            end
         end
      end
   end

`ifdef FEEDER_DROP_CNT_EN
   always_ff @(posedge clk or negedge res) begin
      if (!res)                             drop_cnt <= '0;
      else if (w_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_hist_stream_feeder.sv
// Directed bench for hist_stream_feeder with default parameters (NP=10, 3 pixels, 1 slot, 2 acqs/frame).
module tb_hist_stream_feeder;

   logic       clk = 1'b0;
   logic       res, acq_end, tdc_valid, tdc_ready;
   logic [1:0] tdc_pixel;
   logic [9:0] tdc_word0, tdc_word1, data;
   logic       wrEn, acq_done, hist_done, overflow;
`ifdef FEEDER_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hist_stream_feeder dut (
      .clk(clk), .res(res), .acq_end(acq_end), .tdc_valid(tdc_valid), .tdc_ready(tdc_ready),
      .tdc_pixel(tdc_pixel), .tdc_word0(tdc_word0), .tdc_word1(tdc_word1),
      .wrEn(wrEn), .data(data), .acq_done(acq_done), .hist_done(hist_done), .overflow(overflow)
`ifdef FEEDER_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic ev(input logic [1:0] pix, input logic [9:0] w0, input logic [9:0] w1);
      tdc_valid = 1'b1; tdc_pixel = pix; tdc_word0 = w0; tdc_word1 = w1;
      step();
      tdc_valid = 1'b0;
   endtask

   task automatic acq();
      acq_end = 1'b1;
      step();
      acq_end = 1'b0;
   endtask

   // Called one cycle after acq_end was sampled; leaves time at the acq_done cycle
   task automatic burst(input string tag, input logic [5:0][9:0] exp, input logic hd);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("%s wrEn[%0d]", tag, i), wrEn, 1);
         chk($sformatf("%s data[%0d]", tag, i), data, exp[5-i]);
         chk($sformatf("%s ready[%0d]", tag, i), tdc_ready, 0);
         chk($sformatf("%s acq_done[%0d]", tag, i), acq_done, 0);
         step();
      end
      chk({tag, " end wrEn"}, wrEn, 0);
      chk({tag, " end data"}, data, 0);
      chk({tag, " acq_done"}, acq_done, 1);
      chk({tag, " hist_done"}, hist_done, hd);
      chk({tag, " end ready"}, tdc_ready, 1);
   endtask

   initial begin
      res = 1'b0; acq_end = 1'b0; tdc_valid = 1'b0; tdc_pixel = '0; tdc_word0 = '0; tdc_word1 = '0;
      step(); step();
      chk("rst ready", tdc_ready, 1);
      chk("rst wrEn", wrEn, 0);
      chk("rst data", data, 0);
      chk("rst acq_done", acq_done, 0);
      chk("rst hist_done", hist_done, 0);
      chk("rst overflow", overflow, 0);
      res = 1'b1;
      step();

      // Pixel-major ordering regardless of arrival order
      ev(2'd2, 10'd5, 10'd6);
      ev(2'd0, 10'd108, 10'd511);
      ev(2'd1, 10'd1022, 10'd1022);
      acq();
      burst("t1", {10'd108, 10'd511, 10'd1022, 10'd1022, 10'd5, 10'd6}, 1'b0);

      // Single pixel, empty slots read as 0; second acq of frame
      ev(2'd1, 10'd200, 10'd90);
      acq();
      burst("t2", {10'd0, 10'd0, 10'd200, 10'd90, 10'd0, 10'd0}, 1'b1);
      chk("t2 overflow", overflow, 0);

      // Full slot and out-of-range pixel both drop; counter wrapped so hist_done=0
      ev(2'd0, 10'd300, 10'd500);
      ev(2'd0, 10'd50, 10'd1000);
      ev(2'd3, 10'd7, 10'd7);
      chk("t3 overflow", overflow, 1);
`ifdef FEEDER_DROP_CNT_EN
      chk("t3 drop_cnt", drop_cnt, 2);
`endif
      acq();
      burst("t3", {10'd300, 10'd500, 10'd0, 10'd0, 10'd0, 10'd0}, 1'b0);
      chk("t3 overflow sticky", overflow, 1);

      // Fresh frame: three back-to-back empty acquisitions
      res = 1'b0; step(); res = 1'b1; step();
      chk("t4 overflow cleared", overflow, 0);
      acq();
      burst("t4a", '0, 1'b0);
      acq();
      burst("t4b", '0, 1'b1);
      acq();
      burst("t4c", '0, 1'b0);

      // Reset in the third EMIT cycle
      res = 1'b0; step(); res = 1'b1; step();
      ev(2'd0, 10'd11, 10'd12);
      acq();
      chk("t5 word0", data, 11);
      step(); step();
      chk("t5 word2", data, 0);
      chk("t5 wrEn pre", wrEn, 1);
      res = 1'b0;
      #1;
      chk("t5 wrEn async", wrEn, 0);
      chk("t5 ready async", tdc_ready, 1);
      chk("t5 data async", data, 0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk($sformatf("t5 no acq_done[%0d]", i), acq_done, 0);
         chk($sformatf("t5 no hist_done[%0d]", i), hist_done, 0);
      end
      res = 1'b1;
      step();
      acq();
      burst("t5a", '0, 1'b0);
      ev(2'd0, 10'd13, 10'd14);
      acq();
      burst("t5b", {10'd13, 10'd14, 10'd0, 10'd0, 10'd0, 10'd0}, 1'b1);

      // Event coincident with acq_end is kept; event during EMIT is refused, not dropped
      tdc_valid = 1'b1; tdc_pixel = 2'd2; tdc_word0 = 10'd9; tdc_word1 = 10'd9; acq_end = 1'b1;
      step();
      acq_end = 1'b0; tdc_pixel = 2'd0; tdc_word0 = 10'd1; tdc_word1 = 10'd2;
      burst("t6", {10'd0, 10'd0, 10'd0, 10'd0, 10'd9, 10'd9}, 1'b0);
      tdc_valid = 1'b0;
      chk("t6 overflow", overflow, 0);
`ifdef FEEDER_DROP_CNT_EN
      chk("t6 drop_cnt", drop_cnt, 0);
`endif
      step();
      chk("t6 acq_done clears", acq_done, 0);
      acq();
      burst("t6b", '0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hist_stream_feeder.md
Name: hist_stream_feeder

Overview:
- Transmit side of the histogram builder's `data`/`wrEn` write interface.
- Collects per-pixel TDC timestamp pairs from the pixel front-end during one acquisition (laser period).
- At acquisition end, replays them to the histogram builder in fixed pixel-major order, one `Np`-bit word per clock.
- Counts acquisitions and flags completion of a full histogram frame after `ACQ_NUM` acquisitions.

Parameters:
- NP, 10, timestamp word width (matches `` `Np ``).
- PIXEL_NUM, 3, pixels served by this feeder.
- ACQ_NUM, 2, acquisitions per histogram frame.
- DATA_NUM, 1, event slots per pixel per acquisition; each event is two words.
- PIX_W, 2, width of pixel index; must be ≥ clog2(PIXEL_NUM).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- res  in  1  asynchronous, active-low reset.
- acq_end  in  1  one-cycle pulse: current acquisition window closed.
- tdc_valid  in  1  front-end event valid.
- tdc_ready  out  1  feeder can accept an event.
- tdc_pixel  in  PIX_W  pixel index of the event.
- tdc_word0  in  NP  first timestamp word.
- tdc_word1  in  NP  second timestamp word.
- wrEn  out  1  write strobe to histogram builder.
- data  out  NP  word to histogram builder.
- acq_done  out  1  one-cycle pulse after the last word of each acquisition.
- hist_done  out  1  one-cycle pulse after the last word of acquisition ACQ_NUM.
- overflow  out  1  sticky: an event was dropped since reset.

Behaviour:
- Reset values (res low, asynchronous): state=COLLECT, tdc_ready=1, wrEn=0, data=0, acq_done=0, hist_done=0, overflow=0, all slot counts 0, acq counter 0, buffer contents 0.
- Storage: PIXEL_NUM×DATA_NUM slots, each holding {word0, word1}. Each pixel has a slot count 0..DATA_NUM.
- COLLECT state:
  - tdc_ready=1.
  - An event is accepted when tdc_valid&&tdc_ready at a clock edge. It is written to slot[pixel][count[pixel]] and count[pixel] increments.
  - The event is dropped, and overflow set, if pixel≥PIXEL_NUM or count[pixel]==DATA_NUM.
- acq_end sampled high in COLLECT:
  - An event accepted in the same cycle is included.
  - Next state is EMIT; tdc_ready goes 0 from the next cycle.
- EMIT state: emits exactly PIXEL_NUM×DATA_NUM×2 words.
  - Order: for pixel 0..PIXEL_NUM-1, for slot 0..DATA_NUM-1: word0, then word1.
  - Empty slots (index ≥ count) emit 0. wrEn=1 still (the builder treats 0 as a no-event code).
  - First word appears on data/wrEn the cycle after acq_end is sampled. Words are registered, one per cycle, and wrEn stays high continuously for the whole burst.
  - acq_end during EMIT is ignored.
- After the last word:
  - wrEn=0 and data=0 in the next cycle.
  - acq_done pulses in that same cycle.
  - All counts clear; state returns to COLLECT with tdc_ready=1 in that cycle.
- Acquisition counter:
  - Increments at each acq_done.
  - When the finishing acquisition is number ACQ_NUM, hist_done pulses together with acq_done, and the counter wraps to 0.
- Reset asserted mid-EMIT: burst aborts immediately, with no partial completion pulses. After release, the block is in COLLECT with an empty buffer and acq counter 0.
- overflow clears only on reset.

Optional Feature:
- Macro: FEEDER_DROP_CNT_EN.
- When defined: adds output port drop_cnt [7:0].
  - Counts dropped events, saturating at 255, cleared only on reset.
  - Two drops cannot occur in one cycle, so the increment is by 1.
- When undefined: the port and counter are absent. The overflow flag is unaffected either way.

Test Plan:
- Defaults. Events in COLLECT: pixel2 (5,6), pixel0 (108,511), pixel1 (1022,1022); then pulse acq_end.
  - Next cycle onward, data = 108,511,1022,1022,5,6 with wrEn=1 for exactly 6 cycles.
  - Then wrEn=0, acq_done=1, hist_done=0.
- Only pixel1 (200,90) sent, then acq_end.
  - data = 0,0,200,90,0,0 with wrEn high for 6 cycles. overflow stays 0.
- Pixel0 sent twice, (300,500) then (50,1000), plus pixel index 3 (7,7).
  - Second pixel0 event and the pixel 3 event are dropped; overflow=1.
  - Emitted burst starts 300,500. drop_cnt=2 when FEEDER_DROP_CNT_EN is defined.
- Two complete acquisitions back-to-back.
  - hist_done=0 at the first acq_done and 1 at the second.
  - A third acquisition yields hist_done=0 (counter wrapped).
- res driven low on the 3rd EMIT cycle, released 2 cycles later.
  - wrEn=0 and tdc_ready=1 immediately on assertion; no acq_done.
  - A new acquisition then emits from pixel 0 with hist_done after ACQ_NUM=2 further acquisitions.
- tdc_valid with pixel2 (9,9) in the same cycle as acq_end.
  - Event is included: last two words are 9,9.
  - An event offered while in EMIT is not accepted (tdc_ready=0) and is not counted as a drop.
